// File: rtl/seven_seg_scan_ctrl_if.sv
// rtl/seven_seg_scan_ctrl_if.sv - value/load/enable inputs and anode/segment outputs of the scan controller
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic [6:0]              seg;
  logic                    frame_done;

  modport master (
    output enable, load, value,
    input  digit_sel, seg, frame_done
  );

  modport slave (
    input  enable, load, value,
    output digit_sel, seg, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed common-anode seven-segment scan controller
// BCD to segment decoder; bit6=a .. bit0=g, non-BCD nibbles are dark.
module seven_seg_display (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
  end
endmodule

module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYC     = 8,
  parameter int BLANK_LZ    = 1
) (
  input logic                clk,
  input logic                rst,
  seven_seg_scan_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        div_cnt_q, div_cnt_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic [6:0]              seg_q, seg_d;
  logic                    frame_done_q, frame_done_d;
  logic                    frame_tick;
  logic [3:0]              cur_nib;
  logic [6:0]              dec_seg;
  logic                    lz_blank;

  seven_seg_display u_dec (
    .bcd (cur_nib),
    .seg (dec_seg)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    div_cnt_d  = div_cnt_q;
    pending_d  = pending_q;
    active_d   = active_q;
    shadow_d   = shadow_q;
    frame_tick = 1'b0;
    if (state_q == IDLE) begin
      if (bus.load) begin
        active_d  = bus.value;
        idx_d     = '0;
        div_cnt_d = '0;
        state_d   = GAP;
      end
    end else begin
      if (bus.enable) begin
        if (div_cnt_q == LAST_CNT) begin
          div_cnt_d = '0;
          state_d   = GAP;
          idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            frame_tick = 1'b1;
            if (pending_q) begin
              active_d  = shadow_q;
              pending_d = 1'b0;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
          if (div_cnt_q == GAP_END) state_d = SHOW;
        end
      end
      // A load landing on the frame boundary bypasses the shadow entirely.
      if (bus.load && frame_tick) begin
        active_d  = bus.value;
        pending_d = 1'b0;
      end else if (bus.load) begin
        shadow_d  = bus.value;
        pending_d = 1'b1;
      end
    end
  end

  // Outputs are derived from next-state values so the registers line up with the state.
  always_comb begin
    cur_nib  = active_d[4*int'(idx_d) +: 4];
    lz_blank = 1'b0;
    if (BLANK_LZ != 0 && idx_d != '0) begin
      lz_blank = 1'b1;
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (j >= int'(idx_d) && active_d[4*j +: 4] != 4'd0) lz_blank = 1'b0;
      end
    end
    digit_sel_d = '1;
    seg_d       = '0;
    if (bus.enable && state_d == SHOW) begin
      digit_sel_d[idx_d] = 1'b0;
      if (!lz_blank) seg_d = dec_seg;
    end
    frame_done_d = bus.enable && state_d == SHOW && div_cnt_d == LAST_CNT && idx_d == LAST_IDX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      div_cnt_q    <= '0;
      pending_q    <= 1'b0;
      active_q     <= '0;
      shadow_q     <= '0;
      digit_sel_q  <= '1;
      seg_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      div_cnt_q    <= div_cnt_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      digit_sel_q  <= digit_sel_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.digit_sel  = digit_sel_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - directed bench for seven_seg_scan_ctrl (4 digits, 6-cycle slots, 2-cycle gap)
module tb_seven_seg_scan_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (6),
    .GAP_CYC     (2),
    .BLANK_LZ    (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    bus.value  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int t = 0; t < 100; t++) begin
      checks++;
      if ({bus.digit_sel, bus.seg, bus.frame_done} !== {4'b1111, 7'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle t=%0d got ds=%b seg=%b fd=%b exp ds=1111 seg=0000000 fd=0",
                 t, bus.digit_sel, bus.seg, bus.frame_done);
      end
      tick();
    end
  endtask

  task automatic test_scan();
    logic [6:0] segs [4] = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
    logic [3:0] exp_ds;
    logic [6:0] exp_sg;
    do_reset();
    do_load(16'h1234);
    for (int p = 0; p < 24; p++) begin
      exp_ds = (p % 6 < 2) ? 4'b1111 : ~(4'b0001 << (p / 6));
      exp_sg = (p % 6 < 2) ? 7'd0 : segs[p / 6];
      checks++;
      if ({bus.digit_sel, bus.seg, bus.frame_done} !== {exp_ds, exp_sg, p == 23}) begin
        errors++;
        $display("FAIL scan_1234 p=%0d got ds=%b seg=%b fd=%b exp ds=%b seg=%b fd=%b",
                 p, bus.digit_sel, bus.seg, bus.frame_done, exp_ds, exp_sg, p == 23);
      end
      tick();
    end
  endtask

  task automatic test_blank();
    logic [15:0] vals [3] = '{16'h0007, 16'h0000, 16'h0A00};
    logic [6:0]  tab [3][4] = '{
      '{7'b1110000, 7'b0000000, 7'b0000000, 7'b0000000},
      '{7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000},
      '{7'b1111110, 7'b1111110, 7'b0000000, 7'b0000000}};
    logic [3:0] exp_ds;
    logic [6:0] exp_sg;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      do_load(vals[k]);
      for (int p = 0; p < 24; p++) begin
        exp_ds = (p % 6 < 2) ? 4'b1111 : ~(4'b0001 << (p / 6));
        exp_sg = (p % 6 < 2) ? 7'd0 : tab[k][p / 6];
        checks++;
        if ({bus.digit_sel, bus.seg, bus.frame_done} !== {exp_ds, exp_sg, p == 23}) begin
          errors++;
          $display("FAIL blank_%h p=%0d got ds=%b seg=%b fd=%b exp ds=%b seg=%b fd=%b",
                   vals[k], p, bus.digit_sel, bus.seg, bus.frame_done, exp_ds, exp_sg, p == 23);
        end
        tick();
      end
    end
  endtask

  task automatic test_no_tearing();
    logic [6:0] s1234 [4] = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
    logic [6:0] s0007 [4] = '{7'b1110000, 7'b0000000, 7'b0000000, 7'b0000000};
    logic [3:0] exp_ds;
    logic [6:0] exp_sg;
    int f, p;
    do_reset();
    do_load(16'h1234);
    for (int c = 0; c < 96; c++) begin
      f = c / 24;
      p = c % 24;
      exp_ds = (p % 6 < 2) ? 4'b1111 : ~(4'b0001 << (p / 6));
      if (p % 6 < 2)   exp_sg = 7'd0;
      else if (f == 0) exp_sg = s1234[p / 6];
      else if (f == 1) exp_sg = 7'b1111011;
      else             exp_sg = s0007[p / 6];
      checks++;
      if ({bus.digit_sel, bus.seg, bus.frame_done} !== {exp_ds, exp_sg, p == 23}) begin
        errors++;
        $display("FAIL no_tearing c=%0d got ds=%b seg=%b fd=%b exp ds=%b seg=%b fd=%b",
                 c, bus.digit_sel, bus.seg, bus.frame_done, exp_ds, exp_sg, p == 23);
      end
      if (c == 8)  begin bus.value = 16'h5678; bus.load = 1'b1; end
      if (c == 15) begin bus.value = 16'h9999; bus.load = 1'b1; end
      if (c == 30) begin bus.value = 16'h1234; bus.load = 1'b1; end
      if (c == 47) begin bus.value = 16'h0007; bus.load = 1'b1; end
      tick();
      bus.load = 1'b0;
    end
  endtask

  task automatic test_enable();
    logic [6:0] segs [4] = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
    logic [3:0] exp_ds;
    logic [6:0] exp_sg;
    logic       exp_fd;
    int p;
    do_reset();
    do_load(16'h1234);
    for (int t = 0; t < 36; t++) begin
      if (t >= 16 && t < 26) begin
        exp_ds = 4'b1111;
        exp_sg = 7'd0;
        exp_fd = 1'b0;
      end else begin
        p = (t < 16) ? t : t - 10;
        exp_ds = (p % 6 < 2) ? 4'b1111 : ~(4'b0001 << ((p / 6) % 4));
        exp_sg = (p % 6 < 2) ? 7'd0 : segs[(p / 6) % 4];
        exp_fd = (p == 23);
      end
      checks++;
      if ({bus.digit_sel, bus.seg, bus.frame_done} !== {exp_ds, exp_sg, exp_fd}) begin
        errors++;
        $display("FAIL enable_gap t=%0d got ds=%b seg=%b fd=%b exp ds=%b seg=%b fd=%b",
                 t, bus.digit_sel, bus.seg, bus.frame_done, exp_ds, exp_sg, exp_fd);
      end
      if (t == 15) bus.enable = 1'b0;
      if (t == 25) bus.enable = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] segs [4] = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
    logic [3:0] exp_ds;
    logic [6:0] exp_sg;
    do_reset();
    do_load(16'h1234);
    for (int t = 0; t < 10; t++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int t = 0; t < 20; t++) begin
      checks++;
      if ({bus.digit_sel, bus.seg, bus.frame_done} !== {4'b1111, 7'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_mid t=%0d got ds=%b seg=%b fd=%b exp ds=1111 seg=0000000 fd=0",
                 t, bus.digit_sel, bus.seg, bus.frame_done);
      end
      tick();
    end
    do_load(16'h1234);
    for (int p = 0; p < 8; p++) begin
      exp_ds = (p % 6 < 2) ? 4'b1111 : ~(4'b0001 << (p / 6));
      exp_sg = (p % 6 < 2) ? 7'd0 : segs[p / 6];
      checks++;
      if ({bus.digit_sel, bus.seg, bus.frame_done} !== {exp_ds, exp_sg, 1'b0}) begin
        errors++;
        $display("FAIL restart p=%0d got ds=%b seg=%b fd=%b exp ds=%b seg=%b fd=0",
                 p, bus.digit_sel, bus.seg, bus.frame_done, exp_ds, exp_sg);
      end
      tick();
    end
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.load   = 1'b0;
    bus.value  = '0;
    test_reset();
    test_scan();
    test_blank();
    test_no_tearing();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
